// File: rtl/mlp_pkg.sv
// mlp_pkg: sizes, parameter-memory map, state encoding and Q16.16 helpers
// shared by the SoH MLP sequencer and its testbench.
package mlp_pkg;
    localparam int N_IN  = 4;
    localparam int N_H1  = 64;
    localparam int N_H2  = 32;
    localparam int N_H3  = 16;
    localparam int DW    = 32;
    localparam int FRAC  = 16;
    localparam int AW    = 12;
    localparam int MAX_N = 64;
    localparam int IW    = 7;
    localparam logic [AW-1:0] L1_BASE   = 12'd0;
    localparam logic [AW-1:0] L2_BASE   = 12'd320;
    localparam logic [AW-1:0] L3_BASE   = 12'd2400;
    localparam logic [AW-1:0] L4_BASE   = 12'd2928;
    localparam logic [AW-1:0] LAST_ADDR = 12'd2944;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BIAS, S_MAC, S_WB, S_DONE} state_t;
    function automatic logic [IW-1:0] layer_in(input logic [1:0] l);
        return (l == 2'd0) ? IW'(N_IN) : (l == 2'd1) ? IW'(N_H1) : (l == 2'd2) ? IW'(N_H2) : IW'(N_H3);
    endfunction
    function automatic logic [IW-1:0] layer_out(input logic [1:0] l);
        return (l == 2'd0) ? IW'(N_H1) : (l == 2'd1) ? IW'(N_H2) : (l == 2'd2) ? IW'(N_H3) : IW'(1);
    endfunction
    // Full 64-bit signed product, arithmetic shift (floors), then keep the low word.
    function automatic logic [DW-1:0] fx_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [2*DW-1:0] p;
        p = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
        return DW'(p >>> FRAC);
    endfunction
endpackage

// File: rtl/mlp_inference_sequencer_if.sv
// mlp_inference_sequencer_if: host handshake and parameter-memory read bus
// of the MLP sequencer; slave is the sequencer side.
interface mlp_inference_sequencer_if;
    import mlp_pkg::*;
    logic                 start;
    logic [N_IN*DW-1:0]   in_data;
    logic                 busy;
    logic                 done;
    logic [AW-1:0]        wmem_addr;
    logic                 wmem_rd_en;
    logic [DW-1:0]        wmem_rdata;
    logic [DW-1:0]        soh_out;
    logic [1:0]           layer_idx;
    modport master (
        output start, in_data, wmem_rdata,
        input  busy, done, wmem_addr, wmem_rd_en, soh_out, layer_idx
    );
    modport slave (
        input  start, in_data, wmem_rdata,
        output busy, done, wmem_addr, wmem_rd_en, soh_out, layer_idx
    );
endinterface

// File: rtl/mlp_act_pingpong.sv
// mlp_act_pingpong: two 64-word activation banks; the src bank is read
// combinationally, the other bank is written, and the roles swap per layer.
module mlp_act_pingpong import mlp_pkg::*; (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [N_IN*DW-1:0] load_data_i,
    input  logic               swap_i,
    input  logic               wr_en_i,
    input  logic [5:0]         wr_idx_i,
    input  logic [DW-1:0]      wr_data_i,
    input  logic [5:0]         rd_idx_i,
    output logic [DW-1:0]      rd_data_o
);
    logic [DW-1:0] mem_q [2][MAX_N];
    logic          sel_q, sel_d;
    assign sel_d = load_i ? 1'b0 : swap_i ? ~sel_q : sel_q;
    assign rd_data_o = mem_q[sel_q][rd_idx_i];
    always_ff @(posedge clk) begin
        if (reset) sel_q <= 1'b0;
        else sel_q <= sel_d;
    end
    // Input vector lands in bank 0 with element 0 taken from the MSB word.
    always_ff @(posedge clk) begin
        if (load_i) begin
            for (int k = 0; k < N_IN; k++) mem_q[0][k] <= load_data_i[(N_IN-1-k)*DW +: DW];
        end else if (wr_en_i) begin
            mem_q[~sel_q][wr_idx_i] <= wr_data_i;
        end
    end
endmodule

// File: rtl/mlp_inference_sequencer.sv
// mlp_inference_sequencer: runs the 4-64-32-16-1 SoH MLP on one shared MAC,
// streaming bias/weights from parameter memory and ping-ponging activations.
module mlp_inference_sequencer import mlp_pkg::*; (
    input logic                       clk,
    input logic                       reset,
    mlp_inference_sequencer_if.slave  bus
);
    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    layer_q, layer_d;
    logic [IW-1:0] neuron_q, neuron_d, j_q, j_d, in_n, rd_idx;
    logic [DW-1:0] acc_q, acc_d, soh_q, soh_d, act, sum, relu;
    logic          load, swap, wr_en, last_neuron, last_in;

    mlp_act_pingpong u_act (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load),
        .load_data_i (bus.in_data),
        .swap_i      (swap),
        .wr_en_i     (wr_en),
        .wr_idx_i    (neuron_q[5:0]),
        .wr_data_i   (relu),
        .rd_idx_i    (rd_idx[5:0]),
        .rd_data_o   (act)
    );

    assign in_n        = layer_in(layer_q);
    assign last_neuron = neuron_q == layer_out(layer_q) - IW'(1);
    assign last_in     = j_q == in_n - IW'(1);
    // rdata always lags its read by one cycle, so the activation index lags j by one too.
    assign rd_idx      = (state_q == S_WB) ? in_n - IW'(1) : j_q - IW'(1);
    assign sum         = acc_q + fx_mul(act, bus.wmem_rdata);
    assign relu        = sum[DW-1] ? '0 : sum;

    assign bus.busy       = state_q != S_IDLE;
    assign bus.done       = state_q == S_DONE;
    assign bus.wmem_rd_en = (state_q == S_BIAS) || (state_q == S_MAC);
    assign bus.wmem_addr  = addr_q;
    assign bus.soh_out    = soh_q;
    assign bus.layer_idx  = layer_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            layer_q  <= '0;
            neuron_q <= '0;
            j_q      <= '0;
            acc_q    <= '0;
            soh_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            layer_q  <= layer_d;
            neuron_q <= neuron_d;
            j_q      <= j_d;
            acc_q    <= acc_d;
            soh_q    <= soh_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        layer_d  = layer_q;
        neuron_d = neuron_q;
        j_d      = j_q;
        acc_d    = acc_q;
        soh_d    = soh_q;
        load     = 1'b0;
        swap     = 1'b0;
        wr_en    = 1'b0;
        unique case (state_q)
            S_IDLE: if (bus.start) begin
                state_d  = S_LOAD;
                load     = 1'b1;
                addr_d   = '0;
                layer_d  = '0;
                neuron_d = '0;
                j_d      = '0;
            end
            S_LOAD: state_d = S_BIAS;
            S_BIAS: begin
                addr_d  = addr_q + AW'(1);
                j_d     = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                addr_d  = addr_q + AW'(1);
                acc_d   = (j_q == '0) ? bus.wmem_rdata : sum;
                j_d     = j_q + IW'(1);
                state_d = last_in ? S_WB : S_MAC;
            end
            S_WB: begin
                if (layer_q == 2'd3) begin
                    soh_d   = sum;
                    state_d = S_DONE;
                end else begin
                    wr_en    = 1'b1;
                    swap     = last_neuron;
                    neuron_d = last_neuron ? '0 : neuron_q + IW'(1);
                    layer_d  = last_neuron ? layer_q + 2'd1 : layer_q;
                    state_d  = S_BIAS;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
endmodule
